// File: rtl/param_sequence_detector_if.sv
// Bundle of control, serial-bit and result signals between a bit source and the
// programmable sequence detector.
interface param_sequence_detector_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               load;
    logic [MAX_LEN-1:0] pat_in;
    logic [LEN_W-1:0]   len_in;
    logic               X;
    logic               X_valid;
    logic               M;
    logic               OV;
    logic               Z;
    logic [LEN_W-1:0]   Q;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output load, pat_in, len_in, X, X_valid, M, OV,
        input  Z, Q, match_cnt
    );

    modport slave (
        input  load, pat_in, len_in, X, X_valid, M, OV,
        output Z, Q, match_cnt
    );
endinterface

// File: rtl/param_sequence_detector.sv
// Runtime-programmable serial sequence detector: overlap/non-overlap matching,
// Moore/Mealy output select and a saturating detection counter.
module param_sequence_detector #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input logic                       clk,
    input logic                       reset,
    param_sequence_detector_if.slave  bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = $clog2(MAX_LEN);

    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [LEN_W-1:0]   r_q;
    logic               r_moore_z;
    logic [CNT_W-1:0]   r_cnt;

    logic [MAX_LEN-1:0] w_hist_n;
    logic [LEN_W-1:0]   w_fill_n;
    logic [LEN_W-1:0]   w_q_n;
    logic               w_match;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len < LEN_W'(2))
            return LEN_W'(2);
        else if (len > LEN_W'(MAX_LEN))
            return LEN_W'(MAX_LEN);
        else
            return len;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    function automatic logic full_match(input logic [MAX_LEN-1:0] hist,
                                        input logic [MAX_LEN-1:0] pat,
                                        input logic [LEN_W-1:0]   len);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_LEN; i++)
            if (i < int'(len) && hist[IDX_W'(i)] != pat[IDX_W'(i)])
                ok = 1'b0;
        return ok;
    endfunction

    // Longest k < len whose last k received bits equal the first k pattern bits.
    function automatic logic [LEN_W-1:0] prefix_len(input logic [MAX_LEN-1:0] hist,
                                                    input logic [LEN_W-1:0]   fill,
                                                    input logic [MAX_LEN-1:0] pat,
                                                    input logic [LEN_W-1:0]   len);
        logic [LEN_W-1:0] best;
        logic             ok;
        int               idx;
        best = '0;
        for (int k = 1; k < MAX_LEN; k++) begin
            if (k < int'(len) && k <= int'(fill)) begin
                ok = 1'b1;
                for (int i = 0; i < k; i++) begin
                    idx = int'(len) - k + i;
                    if (hist[IDX_W'(i)] != pat[idx[IDX_W-1:0]])
                        ok = 1'b0;
                end
                if (ok)
                    best = LEN_W'(k);
            end
        end
        return best;
    endfunction

    always_comb begin
        w_hist_n = (r_hist << 1) | MAX_LEN'(bus.X);
        w_fill_n = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
        w_q_n    = prefix_len(w_hist_n, w_fill_n, r_pat, r_len);
        w_match  = bus.X_valid & ~bus.load & ~reset &
                   (r_fill >= r_len - LEN_W'(1)) &
                   full_match(w_hist_n, r_pat, r_len);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pat     <= '0;
            r_len     <= LEN_W'(2);
            r_hist    <= '0;
            r_fill    <= '0;
            r_q       <= '0;
            r_moore_z <= 1'b0;
            r_cnt     <= '0;
        end else if (bus.load) begin
            r_pat     <= bus.pat_in;
            r_len     <= clamp_len(bus.len_in);
            r_hist    <= '0;
            r_fill    <= '0;
            r_q       <= '0;
            r_moore_z <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_moore_z <= w_match;
            if (bus.X_valid) begin
                r_hist <= w_hist_n;
                // Non-overlapping mode forgets every bit of a completed match.
                if (w_match && !bus.OV) begin
                    r_fill <= '0;
                    r_q    <= '0;
                end else begin
                    r_fill <= w_fill_n;
                    r_q    <= w_q_n;
                end
            end
            if (w_match)
                r_cnt <= sat_inc(r_cnt);
        end
    end

    assign bus.Z         = reset ? 1'b0 : (bus.M ? w_match : r_moore_z);
    assign bus.Q         = r_q;
    assign bus.match_cnt = r_cnt;
endmodule

// File: tb/tb_param_sequence_detector.sv
// Directed bench for param_sequence_detector: a vector table on one instance plus
// hand-written reset/Moore and counter-saturation sequences.
module tb_param_sequence_detector;
    typedef struct {
        logic       rst;
        logic       ld;
        logic [7:0] pat;
        logic [3:0] len;
        logic       x;
        logic       xv;
        logic       m;
        logic       ov;
        logic       ez;
        logic [3:0] eq;
        logic [7:0] ec;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   total = 0;
    int   bad   = 0;
    logic cm;
    logic cov;
    vec_t tv[$];

    always #5 clk = ~clk;

    param_sequence_detector_if #(.MAX_LEN(8), .CNT_W(8)) bus_a();
    param_sequence_detector_if #(.MAX_LEN(8), .CNT_W(2)) bus_b();

    param_sequence_detector #(.MAX_LEN(8), .CNT_W(8)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a.slave)
    );

    param_sequence_detector #(.MAX_LEN(8), .CNT_W(2)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b.slave)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, ld, input logic [7:0] pat, input int len,
                                input logic x, xv, m, ov, ez, input int eq, ec);
        vec_t v;
        v.rst = rst; v.ld = ld; v.pat = pat; v.len = 4'(len);
        v.x = x; v.xv = xv; v.m = m; v.ov = ov;
        v.ez = ez; v.eq = 4'(eq); v.ec = 8'(ec);
        return v;
    endfunction

    task automatic bit_v(input logic x, ez, input int eq, ec);
        tv.push_back(mk(1'b0, 1'b0, 8'h00, 0, x, 1'b1, cm, cov, ez, eq, ec));
    endtask

    task automatic idle_v(input logic x, ez, input int eq, ec);
        tv.push_back(mk(1'b0, 1'b0, 8'h00, 0, x, 1'b0, cm, cov, ez, eq, ec));
    endtask

    task automatic load_v(input logic [7:0] pat, input int len, input logic x, xv, ez);
        tv.push_back(mk(1'b0, 1'b1, pat, len, x, xv, cm, cov, ez, 0, 0));
    endtask

    task automatic rst_v(input logic x, xv);
        tv.push_back(mk(1'b1, 1'b0, 8'h00, 0, x, xv, cm, cov, 1'b0, 0, 0));
    endtask

    // Inputs change just after a rising edge; Z is checked at the falling edge
    // (so Mealy sees the current bit) and Q/count just after the next rising edge.
    task automatic run_vec(input vec_t v, input string tag);
        rst_a             = v.rst;
        bus_a.load        = v.ld;
        bus_a.pat_in      = v.pat;
        bus_a.len_in      = v.len;
        bus_a.X           = v.x;
        bus_a.X_valid     = v.xv;
        bus_a.M           = v.m;
        bus_a.OV          = v.ov;
        @(negedge clk);
        chk({tag, "_Z"}, 32'(bus_a.Z), 32'(v.ez));
        @(posedge clk);
        #1;
        chk({tag, "_Q"}, 32'(bus_a.Q), 32'(v.eq));
        chk({tag, "_cnt"}, 32'(bus_a.match_cnt), 32'(v.ec));
    endtask

    task automatic run_b(input logic ld, x, xv, ez, input int eq, ec, input int id);
        rst_b         = 1'b0;
        bus_b.load    = ld;
        bus_b.pat_in  = 8'b0000_0011;
        bus_b.len_in  = 4'd2;
        bus_b.X       = x;
        bus_b.X_valid = xv;
        bus_b.M       = 1'b1;
        bus_b.OV      = 1'b1;
        @(negedge clk);
        chk($sformatf("sat%0d_Z", id), 32'(bus_b.Z), 32'(ez));
        @(posedge clk);
        #1;
        chk($sformatf("sat%0d_Q", id), 32'(bus_b.Q), 32'(eq));
        chk($sformatf("sat%0d_cnt", id), 32'(bus_b.match_cnt), 32'(ec));
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.load = 1'b0; bus_a.pat_in = '0; bus_a.len_in = '0; bus_a.X = 1'b0;
        bus_a.X_valid = 1'b0; bus_a.M = 1'b0; bus_a.OV = 1'b0;
        bus_b.load = 1'b0; bus_b.pat_in = '0; bus_b.len_in = '0; bus_b.X = 1'b0;
        bus_b.X_valid = 1'b0; bus_b.M = 1'b0; bus_b.OV = 1'b0;

        // Reset state in both output modes
        cm = 1'b1; cov = 1'b0; rst_v(1'b1, 1'b1);
        cm = 1'b0; rst_v(1'b0, 1'b0);

        // 010110 twice, Moore, non-overlapping
        cm = 1'b0; cov = 1'b0;
        load_v(8'b0001_0110, 6, 1'b0, 1'b0, 1'b0);
        bit_v(0, 0, 1, 0); bit_v(1, 0, 2, 0); bit_v(0, 0, 3, 0);
        bit_v(1, 0, 4, 0); bit_v(1, 0, 5, 0); bit_v(0, 0, 0, 1);
        bit_v(0, 1, 1, 1); bit_v(1, 0, 2, 1); bit_v(0, 0, 3, 1);
        bit_v(1, 0, 4, 1); bit_v(1, 0, 5, 1); bit_v(0, 0, 0, 2);
        idle_v(0, 1, 0, 2); idle_v(0, 0, 0, 2);

        // 0101 on 0101010, Mealy, overlapping then non-overlapping
        cm = 1'b1; cov = 1'b1;
        load_v(8'b0000_0101, 4, 1'b0, 1'b0, 1'b0);
        bit_v(0, 0, 1, 0); bit_v(1, 0, 2, 0); bit_v(0, 0, 3, 0); bit_v(1, 1, 2, 1);
        bit_v(0, 0, 3, 1); bit_v(1, 1, 2, 2); bit_v(0, 0, 3, 2);
        cov = 1'b0;
        load_v(8'b0000_0101, 4, 1'b0, 1'b0, 1'b0);
        bit_v(0, 0, 1, 0); bit_v(1, 0, 2, 0); bit_v(0, 0, 3, 0); bit_v(1, 1, 0, 1);
        bit_v(0, 0, 1, 1); bit_v(1, 0, 2, 1); bit_v(0, 0, 3, 1);

        // Reset mid-sequence: pattern returns to 00/len 2, so the 1 leaves Q at 0
        cm = 1'b0; cov = 1'b0;
        load_v(8'b0000_0101, 4, 1'b0, 1'b0, 1'b0);
        bit_v(0, 0, 1, 0); bit_v(1, 0, 2, 0); bit_v(0, 0, 3, 0);
        rst_v(1'b1, 1'b1);
        bit_v(1, 0, 0, 0); idle_v(0, 0, 0, 0);

        // Idle gaps with X toggling
        load_v(8'b0000_0101, 4, 1'b0, 1'b0, 1'b0);
        bit_v(0, 0, 1, 0); idle_v(1, 0, 1, 0); bit_v(1, 0, 2, 0); idle_v(0, 0, 2, 0);
        bit_v(0, 0, 3, 0); idle_v(1, 0, 3, 0); bit_v(1, 0, 0, 1); idle_v(0, 1, 0, 1);
        idle_v(1, 0, 0, 1);

        // Length clamping; the bit offered with load is dropped
        cm = 1'b1; cov = 1'b1;
        load_v(8'b0000_0010, 1, 1'b1, 1'b1, 1'b0);
        bit_v(1, 0, 1, 0); bit_v(0, 1, 0, 1);
        cov = 1'b0;
        load_v(8'b1010_1010, 11, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++)
            bit_v(logic'(i % 2 == 0), 0, i + 1, 0);
        bit_v(0, 1, 0, 1);

        @(posedge clk);
        #1;
        for (int i = 0; i < tv.size(); i++)
            run_vec(tv[i], $sformatf("v%0d", i));

        // Moore pulse from the last Mealy-mode match shows through a load cycle,
        // and a pending Moore pulse is suppressed by reset.
        run_vec(mk(1'b0, 1'b1, 8'b0000_0011, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0), "h_load");
        run_vec(mk(1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0), "h_b1");
        run_vec(mk(1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1), "h_b2");
        run_vec(mk(1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0), "h_rst");
        run_vec(mk(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0), "h_idle");

        // Two-bit counter saturation with back-to-back overlapping matches
        rst_a = 1'b0; bus_a.load = 1'b0; bus_a.X_valid = 1'b0;
        run_b(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            run_b(1'b0, 1'b1, 1'b1, logic'(i > 0), 1, (i > 3) ? 3 : i, i + 1);
        run_b(1'b0, 1'b0, 1'b0, 1'b0, 1, 3, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
